// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the DTMF frame sequencer.
// States, widths and the no-tone code.
package tone_seq_pkg;

  localparam int BIN_W  = 16;
  localparam int TONE_W = 16;

  localparam logic [TONE_W-1:0] TONE_NONE = 16'h0000;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CLEAR  = 3'd1;
  localparam state_t S_STREAM = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_EVAL   = 3'd4;

endpackage

// File: rtl/tone_frame_sequencer_if.sv
// Bundle between FFT stage, tone detector and keypad logic.
// slave = sequencer side, master = environment side.
interface tone_frame_sequencer_if;
  import tone_seq_pkg::*;

  logic              start;
  logic              fft_valid;
  logic [BIN_W-1:0]  fft_bin;
  logic              fft_ready;
  logic              det_clear;
  logic              det_enable;
  logic [BIN_W-1:0]  det_bins;
  logic              det_done;
  logic              det_error;
  logic [TONE_W-1:0] det_tone;
  logic              busy;
  logic              digit_valid;
  logic [TONE_W-1:0] digit;
  logic              timeout_err;

  modport slave (
    input  start, fft_valid, fft_bin,
    input  det_done, det_error, det_tone,
    output fft_ready, det_clear, det_enable, det_bins,
    output busy, digit_valid, digit, timeout_err
  );

  modport master (
    output start, fft_valid, fft_bin,
    output det_done, det_error, det_tone,
    input  fft_ready, det_clear, det_enable, det_bins,
    input  busy, digit_valid, digit, timeout_err
  );

endinterface

// File: rtl/tone_debouncer.sv
// Debounces detected tone codes across frames.
// Reports a digit once when a run of equal tones hits the target.
module tone_debouncer
  import tone_seq_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_eval,
  input  logic [TONE_W-1:0] i_tone,
  input  logic              i_clr_all,
  input  logic              i_clr_cnt,
  output logic              o_valid,
  output logic [TONE_W-1:0] o_digit
);

  localparam logic [3:0] DMAX = 4'(DEBOUNCE_FRAMES);

  logic [3:0]        r_cnt;
  logic [TONE_W-1:0] r_last;
  logic              r_valid;
  logic [TONE_W-1:0] r_digit;
  logic [3:0]        w_cnt;
  logic [TONE_W-1:0] w_last;
  logic              w_hold;
  logic              w_hit;

  // next run length and remembered tone for this frame's result
  always_comb begin
    w_cnt  = r_cnt;
    w_last = r_last;
    w_hold = 1'b0;
    if (i_tone == TONE_NONE) begin
      w_cnt  = '0;
      w_last = TONE_NONE;
    end else if (i_tone == r_last) begin
      w_hold = (r_cnt == DMAX);
      w_cnt  = w_hold ? DMAX : r_cnt + 4'd1;
    end else begin
      w_last = i_tone;
      w_cnt  = 4'd1;
    end
  end

  // a held key at saturation must not report again
  assign w_hit = i_eval & (w_cnt == DMAX) & ~w_hold;

  // debounce state, cleared by aborts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_last <= TONE_NONE;
    end else if (i_clr_all) begin
      r_cnt  <= '0;
      r_last <= TONE_NONE;
    end else if (i_clr_cnt) begin
      r_cnt  <= '0;
    end else if (i_eval) begin
      r_cnt  <= w_cnt;
      r_last <= w_last;
    end
  end

  // report pulse and held digit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_digit <= '0;
    end else begin
      r_valid <= w_hit;
      if (w_hit) r_digit <= i_tone;
    end
  end

  assign o_valid = r_valid;
  assign o_digit = r_digit;

endmodule

// File: rtl/tone_frame_sequencer.sv
// Sequences one DTMF detection frame: clear, stream bins, wait, debounce.
// TONE_SEQ_CONTINUOUS_EN: restart frames back-to-back after the first start.
module tone_frame_sequencer
  import tone_seq_pkg::*;
#(
  parameter int NUM_BINS        = 64,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input logic                   clock,
  input logic                   reset,
  tone_frame_sequencer_if.slave bus
);

  localparam int BCW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] LAST_BIN = BCW'(NUM_BINS - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYCLES);

`ifdef TONE_SEQ_CONTINUOUS_EN
  localparam state_t RESUME = S_CLEAR;
`else
  localparam state_t RESUME = S_IDLE;
`endif

  state_t            r_state;
  state_t            w_nxt;
  logic [BCW-1:0]    r_bin_cnt;
  logic [TCW-1:0]    r_tmo_cnt;
  logic [BIN_W-1:0]  r_bins;
  logic              r_beat;
  logic              r_tmo_err;
  logic [TONE_W-1:0] r_tone;
  logic              w_ready;
  logic              w_beat;
  logic              w_last;
  logic              w_wait;
  logic              w_done_ok;
  logic              w_done_err;
  logic              w_tmo;
  logic              w_eval;
  logic              w_dv;
  logic [TONE_W-1:0] w_digit;

  assign w_ready    = (r_state == S_STREAM);
  assign w_beat     = w_ready & bus.fft_valid;
  assign w_last     = w_beat & (r_bin_cnt == LAST_BIN);
  assign w_wait     = (r_state == S_WAIT);
  assign w_done_ok  = w_wait & bus.det_done & ~bus.det_error;
  assign w_done_err = w_wait & bus.det_done & bus.det_error;
  assign w_tmo      = w_wait & ~bus.det_done & (r_tmo_cnt == TMO_MAX);
  assign w_eval     = (r_state == S_EVAL);

  // frame state transitions; a result beats a same-cycle timeout
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_nxt = S_CLEAR;
      S_CLEAR:  w_nxt = S_STREAM;
      S_STREAM: if (w_last) w_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_ok)       w_nxt = S_EVAL;
        else if (w_done_err) w_nxt = RESUME;
        else if (w_tmo)      w_nxt = RESUME;
      end
      S_EVAL:   w_nxt = RESUME;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // state, bin gating and result capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_beat    <= 1'b0;
      r_bins    <= '0;
      r_tmo_err <= 1'b0;
      r_tone    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_beat    <= w_beat;
      r_tmo_err <= w_tmo;
      if (w_beat)    r_bins <= bus.fft_bin;
      if (w_done_ok) r_tone <= bus.det_tone;
    end
  end

  // bin and timeout counters; neither wraps within a frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bin_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if (r_state == S_CLEAR)
        r_bin_cnt <= '0;
      else if (w_beat && !w_last)
        r_bin_cnt <= r_bin_cnt + 1'b1;
      if (w_last)
        r_tmo_cnt <= '0;
      else if (w_wait && r_tmo_cnt != TMO_MAX)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  tone_debouncer #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_deb (
    .clock     (clock),
    .reset     (reset),
    .i_eval    (w_eval),
    .i_tone    (r_tone),
    .i_clr_all (w_done_err),
    .i_clr_cnt (w_tmo),
    .o_valid   (w_dv),
    .o_digit   (w_digit)
  );

  assign bus.fft_ready   = w_ready;
  assign bus.det_clear   = (r_state == S_CLEAR);
  assign bus.det_enable  = r_beat | w_wait;
  assign bus.det_bins    = r_bins;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.digit_valid = w_dv;
  assign bus.digit       = w_digit;
  assign bus.timeout_err = r_tmo_err;

endmodule

// File: tb/tb_tone_frame_sequencer.sv
// Directed bench for tone_frame_sequencer with a cycle timeline model.
// Expected outputs come from frame timing rules and a run-length debounce model.
`timescale 1ns/1ps
module tb_tone_frame_sequencer;

  localparam int NB  = 64;
  localparam int TMO = 255;
  localparam int DEB = 2;

  logic clock = 1'b0;
  logic reset;

  tone_frame_sequencer_if bus();

  tone_frame_sequencer #(
    .NUM_BINS        (NB),
    .TIMEOUT_CYCLES  (TMO),
    .DEBOUNCE_FRAMES (DEB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic        e_busy, e_ready, e_clear, e_en, e_dv, e_tmo;
  logic [15:0] e_bins, e_digit;

  int   dv_seen = 0;
  int   beats_seen = 0;
  int   fb = 0;
  time  t_first, t_last, t_wait, t_tmo;
  logic rp = 1'b0;

  int          run = 0;
  logic [15:0] prev = 16'h0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // run-length view of debouncing: report when a run of equal
  // non-zero tones is exactly DEB frames long
  task automatic model_eval(input logic [15:0] t, output bit rep);
    if (t == 16'h0) begin
      run = 0;
      prev = 16'h0;
    end else if (t == prev) begin
      run++;
    end else begin
      prev = t;
      run = 1;
    end
    rep = (run == DEB);
  endtask

  // single compare process
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy",        32'(bus.busy),        32'(e_busy));
      check("fft_ready",   32'(bus.fft_ready),   32'(e_ready));
      check("det_clear",   32'(bus.det_clear),   32'(e_clear));
      check("det_enable",  32'(bus.det_enable),  32'(e_en));
      check("det_bins",    32'(bus.det_bins),    32'(e_bins));
      check("digit_valid", 32'(bus.digit_valid), 32'(e_dv));
      check("digit",       32'(bus.digit),       32'(e_digit));
      check("timeout_err", 32'(bus.timeout_err), 32'(e_tmo));
      if (bus.digit_valid) dv_seen++;
      if (bus.fft_valid && bus.fft_ready) begin
        beats_seen++;
        if (fb == 0) t_first = $time;
        t_last = $time;
        fb++;
      end
      if (rp && !bus.fft_ready) t_wait = $time;
      if (bus.timeout_err) t_tmo = $time;
      rp = bus.fft_ready;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    e_busy  = 1'b0;
    e_ready = 1'b0;
    e_clear = 1'b0;
    e_en    = 1'b0;
    e_dv    = 1'b0;
    e_tmo   = 1'b0;
  endtask

  function automatic logic [15:0] bin_val(input int k);
    return {8'(k + 1), 8'(~k)};
  endfunction

  // start and clear cycles of a frame
  task automatic frame_head(input bit hold_start);
    tick();
    quiet();
    bus.start = 1'b1;
    tick();
    bus.start = hold_start;
    e_busy  = 1'b1;
    e_clear = 1'b1;
  endtask

  // stream up to nb beats; toggle gives valid on even cycles only
  task automatic stream(input bit toggle, input int nb, inout bit bprev,
                        inout logic [15:0] lastbin);
    int beats = 0;
    int k = 0;
    while (beats < nb) begin
      tick();
      e_clear = 1'b0;
      e_ready = 1'b1;
      e_en    = bprev;
      if (bprev) e_bins = lastbin;
      bus.fft_valid = toggle ? (k % 2 == 0) : 1'b1;
      bus.fft_bin   = bin_val(k);
      bprev = bus.fft_valid;
      if (bprev) begin
        lastbin = bus.fft_bin;
        beats++;
      end
      k++;
    end
  endtask

  // full frame; done_w < 0 means the detector never answers
  task automatic frame(input bit toggle, input int done_w,
                       input logic [15:0] tone, input bit err,
                       input bit hold_start);
    bit          bprev = 1'b0;
    logic [15:0] lastbin = 16'h0;
    bit          rep;
    int          w = 0;
    frame_head(hold_start);
    stream(toggle, NB, bprev, lastbin);
    forever begin
      tick();
      bus.fft_valid = 1'b0;
      if (bprev) e_bins = lastbin;
      bprev   = 1'b0;
      e_ready = 1'b0;
      e_en    = 1'b1;
      if (done_w >= 0 && w == done_w) begin
        bus.det_done  = 1'b1;
        bus.det_error = err;
        bus.det_tone  = tone;
        bus.start     = 1'b0;
        break;
      end
      if (done_w < 0 && w == TMO) begin
        bus.start = 1'b0;
        break;
      end
      w++;
    end
    tick();
    bus.det_done  = 1'b0;
    bus.det_error = 1'b0;
    bus.det_tone  = 16'h0;
    if (done_w < 0) begin
      quiet();
      e_tmo = 1'b1;
      run = 0;
    end else if (err) begin
      quiet();
      run = 0;
      prev = 16'h0;
    end else begin
      e_busy = 1'b1;
      e_en   = 1'b0;
      model_eval(tone, rep);
      tick();
      quiet();
      e_dv = rep;
      if (rep) e_digit = tone;
    end
    tick();
    quiet();
  endtask

  initial begin
    int b0;
    bit          bp;
    logic [15:0] lb;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.fft_valid = 1'b0;
    bus.fft_bin   = 16'h0;
    bus.det_done  = 1'b0;
    bus.det_error = 1'b0;
    bus.det_tone  = 16'h0;
    e_bins  = 16'h0;
    e_digit = 16'h0;
    quiet();
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",  32'(bus.busy),        32'h0);
    check("rst_ready", 32'(bus.fft_ready),   32'h0);
    check("rst_en",    32'(bus.det_enable),  32'h0);
    check("rst_dv",    32'(bus.digit_valid), 32'h0);
    check("rst_digit", 32'(bus.digit),       32'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    b0 = beats_seen;
    frame(1'b0, 4, 16'h0105, 1'b0, 1'b0);
    check("f1_beats", 32'(beats_seen - b0), 32'd64);
    check("f1_no_dv", 32'(dv_seen), 32'd0);
    frame(1'b0, 4, 16'h0105, 1'b0, 1'b0);
    check("f2_dv",    32'(dv_seen), 32'd1);
    check("f2_digit", 32'(bus.digit), 32'h0105);
    frame(1'b0, 2, 16'h0105, 1'b0, 1'b1);
    frame(1'b0, 3, 16'h0000, 1'b0, 1'b0);
    frame(1'b0, 1, 16'h0105, 1'b0, 1'b0);
    check("f5_dv", 32'(dv_seen), 32'd1);

    fb = 0;
    frame(1'b1, 2, 16'h0306, 1'b0, 1'b0);
    check("tog_span", 32'(t_last - t_first), 32'd1260);

    frame(1'b0, -1, 16'h0, 1'b0, 1'b0);
    check("tmo_span", 32'(t_tmo - t_wait), 32'd2560);
    check("tmo_busy", 32'(bus.busy), 32'd0);

    frame(1'b0, 5, 16'h0209, 1'b0, 1'b0);
    frame(1'b0, 5, 16'h0209, 1'b1, 1'b0);
    check("err_no_dv", 32'(dv_seen), 32'd1);
    frame(1'b0, 0, 16'h0209, 1'b0, 1'b0);
    frame(1'b0, 7, 16'h0209, 1'b0, 1'b0);
    check("err_dv",    32'(dv_seen), 32'd2);
    check("err_digit", 32'(bus.digit), 32'h0209);

    bp = 1'b0;
    lb = 16'h0;
    frame_head(1'b0);
    stream(1'b0, 30, bp, lb);
    chk_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_busy",  32'(bus.busy),        32'h0);
    check("mid_ready", 32'(bus.fft_ready),   32'h0);
    check("mid_clear", 32'(bus.det_clear),   32'h0);
    check("mid_en",    32'(bus.det_enable),  32'h0);
    check("mid_bins",  32'(bus.det_bins),    32'h0);
    check("mid_dv",    32'(bus.digit_valid), 32'h0);
    check("mid_digit", 32'(bus.digit),       32'h0);
    check("mid_tmo",   32'(bus.timeout_err), 32'h0);
    bus.fft_valid = 1'b0;
    tick();
    reset = 1'b0;
    quiet();
    e_bins  = 16'h0;
    e_digit = 16'h0;
    run  = 0;
    prev = 16'h0;
    chk_en = 1'b1;
    b0 = beats_seen;
    frame(1'b0, 3, 16'h0105, 1'b0, 1'b0);
    check("post_beats", 32'(beats_seen - b0), 32'd64);
    check("total_dv",   32'(dv_seen), 32'd2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_frame_sequencer.md
Name: tone_frame_sequencer

Overview:
Controller that sequences one DTMF detection frame through the tone-detector datapath. It clears the detector, gates the FFT bin stream into it one bin per valid beat with a bin count, and waits for the detector result with a timeout. It then debounces the 16-bit tone code across consecutive frames and raises a single-cycle digit report. It sits between the FFT output stage and the keypad/command logic.

Parameters:
NUM_BINS, 64, bins streamed per frame; must be >= 45 so the upper tone bins are covered.
TIMEOUT_CYCLES, 255, maximum cycles in WAIT_RESULT before abort.
DEBOUNCE_FRAMES, 2, consecutive identical non-zero tones needed to report; range 1..15.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request one frame; sampled only in IDLE
fft_valid  in  1  fft_bin is valid this cycle
fft_bin  in  16  {real[15:8], imag[7:0]} bin sample
fft_ready  out  1  sequencer accepts a bin this cycle
det_clear  out  1  one-cycle clear pulse to the detector
det_enable  out  1  detector enable
det_bins  out  16  registered bin to the detector
det_done  in  1  detector result valid
det_error  in  1  detector reports an invalid pair
det_tone  in  16  detector tone code; 0 means no tone
busy  out  1  high in any state except IDLE
digit_valid  out  1  one-cycle pulse when a debounced digit is reported
digit  out  16  last reported tone code, held until the next report
timeout_err  out  1  one-cycle pulse on a WAIT_RESULT timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; bin_cnt, tmo_cnt and deb_cnt are 0; last_tone is 0.
- IDLE: when start=1, go to CLEAR. fft_ready=0.
- CLEAR: det_clear=1 for exactly one cycle. Clear bin_cnt. Go to STREAM.
- STREAM: fft_ready=1.
  - On each fft_valid&fft_ready beat: register fft_bin into det_bins and pulse det_enable the next cycle (1-cycle latency), then increment bin_cnt.
  - Gaps in fft_valid hold det_enable low; bin_cnt does not advance.
  - On the beat where bin_cnt reaches NUM_BINS-1: drop fft_ready the next cycle, clear tmo_cnt, go to WAIT_RESULT.
  - bin_cnt width is clog2(NUM_BINS); it never wraps within a frame.
- WAIT_RESULT: det_enable=1 every cycle so the detector's internal counter runs past its latch point. tmo_cnt increments each cycle.
  - det_done=1 with det_error=0: go to EVAL with det_tone captured.
  - det_done=1 with det_error=1: clear deb_cnt and last_tone, go to IDLE.
  - tmo_cnt == TIMEOUT_CYCLES with no done: pulse timeout_err, clear deb_cnt, go to IDLE.
  - done and timeout in the same cycle: done wins.
- EVAL (1 cycle):
  - Captured tone == 0: deb_cnt=0, last_tone=0.
  - Tone == last_tone: deb_cnt saturates at DEBOUNCE_FRAMES.
  - Otherwise: last_tone=tone, deb_cnt=1.
  - If deb_cnt becomes exactly DEBOUNCE_FRAMES on this cycle: pulse digit_valid and load digit. A held key reports once only; repeating requires a different tone or a no-tone frame in between.
  - Then go to IDLE.
- start asserted outside IDLE is ignored and not queued.
- Reset mid-frame returns to IDLE immediately. det_enable and fft_ready drop asynchronously.
- Minimum frame latency, start to digit_valid: NUM_BINS + 3 cycles + detector result latency.

Optional Feature:
TONE_SEQ_CONTINUOUS_EN
- Defined: after EVAL, an error abort or a timeout abort, go directly to CLEAR instead of IDLE. start is only needed once after reset. busy stays high until reset.
- Undefined: each frame requires a start pulse, as described above.

Decomposition:
- Package tone_seq_pkg: state enum (IDLE, CLEAR, STREAM, WAIT_RESULT, EVAL), the TONE_NONE=16'h0000 constant, and the bin/tone width constants (BIN_W=16, TONE_W=16).
- One natural sub-module, tone_debouncer: EVAL compare/saturate logic with last_tone and deb_cnt, producing digit_valid/digit.
- The FSM, counters and stream gating stay in the top module.

Test Plan:
- Reset then start with 64 back-to-back bins, det_done at cycle 70 with tone=16'h0105 -> exactly 64 det_enable pulses during STREAM; no digit_valid after frame 1; digit_valid with digit=16'h0105 after frame 2 (DEBOUNCE_FRAMES=2).
- fft_valid toggled 1/0 every cycle -> bin_cnt reaches 63 after 127 cycles; det_bins matches the input sequence; fft_ready drops after the 64th beat.
- det_done never asserted -> timeout_err pulses exactly 256 cycles after entering WAIT_RESULT; state returns to IDLE; busy=0.
- Three frames tone 0x0105, a frame of tone 0, then a frame of 0x0105 -> one digit_valid after frame 2; none after frames 3-5.
- det_error=1 with det_done on frame 2 of a matching pair -> no digit_valid; the next two good frames report.
- Reset asserted mid-STREAM at bin 30 -> all outputs 0 in the same cycle; a new start performs a full 64-bin frame.
